// File: rtl/pwm_meas.sv
// pwm_meas: measures period, high time and integer duty cycle of an asynchronous PWM input.
// Latency: 8 clk from the synchronised rising edge to valid (input path adds 2 clk, plus FILT_LEN with filter).
// Backpressure: none; results are one-cycle strobes, a period ending mid-divide sets overrun and is dropped.
// Optional glitch filter on the synchronised input: define PWM_MEAS_GLITCH_FILTER_EN.
module pwm_meas #(
    parameter int CNT_W    = 24,
    parameter int TIMEOUT  = 1000000,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pwmIn,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] highTime,
    output logic [7:0]       dutyCycle,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);

    // Dividend 100*H needs 7 extra bits over the counter width.
    localparam int N_W = CNT_W + 7;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

    // Reject parameter sets where the idle counter could not reach TIMEOUT.
    if ((TIMEOUT < 1) || (longint'(TIMEOUT) >= (longint'(1) << CNT_W)) || (FILT_LEN < 1)) begin : gParamCheck
        $error("pwm_meas: TIMEOUT must be in 1..2**CNT_W-1 and FILT_LEN >= 1");
    end

    typedef enum logic [1:0] {
        sIdle,
        sWait,
        sMeas
    } state_t;

    state_t           state;
    state_t           stateNext;

    logic             sync1;
    logic             sync2;
    logic             s;
    logic             sPrev;
    logic             rise;
    logic             anyEdge;

    logic [CNT_W-1:0] perCnt;
    logic [CNT_W-1:0] hiCnt;
    logic [CNT_W-1:0] idleCnt;

    logic             timeoutHit;
    logic             captureOk;
    logic             overrunHit;

    logic             divActive;
    logic [2:0]       divStep;
    logic [N_W-1:0]   divRem;
    logic [CNT_W-1:0] divDen;
    logic [CNT_W-1:0] latH;
    logic [6:0]       divQuo;
    logic [N_W-1:0]   shiftedDen;
    logic             remGe;
    logic [N_W-1:0]   remNext;
    logic [6:0]       quoNext;
    logic             divDone;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwmIn;
            sync2 <= sync1;
        end
    end

`ifdef PWM_MEAS_GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] filtCnt;
    logic            sFilt;

    // Accept a new level only after it has been seen for FILT_LEN consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filtCnt <= '0;
            sFilt   <= 1'b0;
        end else if (sync2 != sFilt) begin
            if (filtCnt == FC_W'(FILT_LEN - 1)) begin
                sFilt   <= sync2;
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end else begin
            filtCnt <= '0;
        end
    end

    assign s = sFilt;
`else
    assign s = sync2;
`endif

    // Previous level of s for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sPrev <= 1'b0;
        end else begin
            sPrev <= s;
        end
    end

    assign rise    = s & ~sPrev;
    assign anyEdge = s ^ sPrev;

    // A timeout can only fire on an edge-free cycle, so a capture always wins.
    assign timeoutHit = enable && (state != sIdle) && !anyEdge && (idleCnt == TO_M1);
    assign captureOk  = enable && (state == sMeas) && rise && !divActive;
    assign overrunHit = enable && (state == sMeas) && rise && divActive;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= sIdle;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state: wait out the partial first period, then measure edge to edge.
    always_comb begin
        stateNext = state;
        case (state)
            sIdle:   if (enable) stateNext = sWait;
            sWait:   if (rise) stateNext = sMeas;
            sMeas:   stateNext = sMeas;
            default: stateNext = sIdle;
        endcase
        if (timeoutHit) begin
            stateNext = sWait;
        end
        if (!enable) begin
            stateNext = sIdle;
        end
    end

    // Period and high-time counters; a rising edge counts as the first cycle of the new period.
    always_ff @(posedge clk) begin
        if (rst || !enable || (state == sIdle)) begin
            perCnt <= '0;
            hiCnt  <= '0;
        end else if (rise) begin
            perCnt <= CNT_W'(1);
            hiCnt  <= CNT_W'(1);
        end else if (state == sMeas) begin
            perCnt <= perCnt + 1'b1;
            if (s) begin
                hiCnt <= hiCnt + 1'b1;
            end
        end
    end

    // Idle counter: cycles since the last edge, saturating so a stuck level reports once.
    always_ff @(posedge clk) begin
        if (rst || !enable || (state == sIdle)) begin
            idleCnt <= '0;
        end else if (anyEdge) begin
            idleCnt <= '0;
        end else if (idleCnt != TO_VAL) begin
            idleCnt <= idleCnt + 1'b1;
        end
    end

    // One restoring step per cycle: try subtracting P shifted to the current quotient bit.
    assign shiftedDen = N_W'(divDen) << divStep;
    assign remGe      = (divRem >= shiftedDen);
    assign remNext    = remGe ? (divRem - shiftedDen) : divRem;
    assign quoNext    = remGe ? (divQuo | (7'd1 << divStep)) : divQuo;
    assign divDone    = divActive && (divStep == 3'd0);

    // Divider: loads at the capture edge, resolves quotient bits 6..0 on the next seven cycles.
    always_ff @(posedge clk) begin
        if (rst || !enable || timeoutHit) begin
            divActive <= 1'b0;
            divStep   <= '0;
            divRem    <= '0;
            divDen    <= '0;
            latH      <= '0;
            divQuo    <= '0;
        end else if (captureOk) begin
            divActive <= 1'b1;
            divStep   <= 3'd6;
            divRem    <= N_W'(hiCnt) * N_W'(100);
            divDen    <= perCnt;
            latH      <= hiCnt;
            divQuo    <= '0;
        end else if (divActive) begin
            divRem <= remNext;
            divQuo <= quoNext;
            if (divStep == 3'd0) begin
                divActive <= 1'b0;
            end else begin
                divStep <= divStep - 3'd1;
            end
        end
    end

    // Result registers: timeout report overrides, otherwise publish the finished divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            period    <= '0;
            highTime  <= '0;
            dutyCycle <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (overrunHit) begin
                overrun <= 1'b1;
            end
            if (timeoutHit) begin
                valid     <= 1'b1;
                stuck     <= 1'b1;
                period    <= '0;
                highTime  <= '0;
                dutyCycle <= s ? 8'd100 : 8'd0;
            end else if (divDone && enable) begin
                valid     <= 1'b1;
                stuck     <= 1'b0;
                period    <= divDen;
                highTime  <= latH;
                dutyCycle <= {1'b0, quoNext};
            end
        end
    end

endmodule
